// File: rtl/gouram_trace_pkg.sv
// Shared definitions for the Gouram trace buffer: opcode constants, FSM states
// and the bit layout of a trace record {jump, mem, instr, addr, latency[, timestamp]}.
package gouram_trace_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_GNT    = 2'd1,
        ST_WAIT_RVALID = 2'd2
    } trace_state_e;

    function automatic logic is_mem_opcode(input logic [6:0] opcode);
        return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    endfunction

    // Timestamp occupies the LSBs; a disabled timestamp has zero width.
    function automatic int ts_field_width(input bit ts_en, input int ts_w);
        return ts_en ? ts_w : 0;
    endfunction

    function automatic int lat_lsb(input int ts_fw);
        return ts_fw;
    endfunction

    function automatic int addr_lsb(input int ts_fw, input int lat_w);
        return ts_fw + lat_w;
    endfunction

    function automatic int instr_lsb(input int ts_fw, input int lat_w, input int addr_w);
        return ts_fw + lat_w + addr_w;
    endfunction

    function automatic int mem_bit(input int ts_fw, input int lat_w, input int addr_w,
                                   input int instr_w);
        return ts_fw + lat_w + addr_w + instr_w;
    endfunction

    function automatic int rec_width(input int ts_fw, input int lat_w, input int addr_w,
                                     input int instr_w);
        return ts_fw + lat_w + addr_w + instr_w + 2;
    endfunction

endpackage

// File: rtl/gouram_trace_fifo.sv
// Synchronous record FIFO with registered head data, full and empty flags.
// A push and a pop in the same cycle both succeed, even when full.
module gouram_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_ptr_nxt_s;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic [WIDTH-1:0] head_nxt_s;
    logic [WIDTH-1:0] data_r;
    logic             full_r;
    logic             empty_r;

    // Next occupancy and the record that will sit at the head after this edge
    always_comb begin
        pop_ok_s     = pop & ~empty_r;
        push_ok_s    = push & (~full_r | pop_ok_s);
        count_nxt_s  = count_r + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
        rd_ptr_nxt_s = rd_ptr_r;
        if (pop_ok_s) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (count_nxt_s == (AW+1)'(0)) begin
            head_nxt_s = '0;
        end else if ((count_r == (AW+1)'(0)) || ((count_r == (AW+1)'(1)) && pop_ok_s)) begin
            head_nxt_s = push_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Pointer, occupancy and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            data_r   <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            data_r   <= head_nxt_s;
            full_r   <= (count_nxt_s == (AW+1)'(DEPTH));
            empty_r  <= (count_nxt_s == (AW+1)'(0));
        end
    end

    // Storage array; slots are only read after being written
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign pop_data = data_r;
    assign full     = full_r;
    assign empty    = empty_r;

endmodule

// File: rtl/gouram_trace_buffer.sv
// Gouram trace front end: pairs fetched instructions with their data-memory
// transaction and queues records. Define GOURAM_TIMESTAMP_EN to add a timestamp field.
module gouram_trace_buffer
    import gouram_trace_pkg::*;
#(
    parameter int INSTR_DATA_WIDTH = 32,
    parameter int DATA_ADDR_WIDTH  = 32,
    parameter int LAT_WIDTH        = 16,
    parameter int TS_WIDTH         = 32,
    parameter int FIFO_DEPTH       = 8,
    parameter int DROP_WIDTH       = 16,
`ifdef GOURAM_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1,
`else
    localparam bit TS_EN = 1'b0,
`endif
    localparam int TS_FW = ts_field_width(TS_EN, TS_WIDTH),
    localparam int REC_W = rec_width(TS_FW, LAT_WIDTH, DATA_ADDR_WIDTH, INSTR_DATA_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        jump_done,
    input  logic                        instr_rvalid,
    input  logic [INSTR_DATA_WIDTH-1:0] instr_rdata,
    input  logic                        data_mem_req,
    input  logic [DATA_ADDR_WIDTH-1:0]  data_mem_addr,
    input  logic                        data_mem_grant,
    input  logic                        data_mem_rvalid,
    output logic                        trace_valid_o,
    input  logic                        trace_ready_i,
    output logic [REC_W-1:0]            trace_data_o,
    output logic [DROP_WIDTH-1:0]       drop_count_o
);

    localparam int LAT_LSB   = lat_lsb(TS_FW);
    localparam int ADDR_LSB  = addr_lsb(TS_FW, LAT_WIDTH);
    localparam int INSTR_LSB = instr_lsb(TS_FW, LAT_WIDTH, DATA_ADDR_WIDTH);
    localparam int MEM_BIT   = mem_bit(TS_FW, LAT_WIDTH, DATA_ADDR_WIDTH, INSTR_DATA_WIDTH);
    localparam int JUMP_BIT  = MEM_BIT + 1;

    trace_state_e                state_r;
    logic [INSTR_DATA_WIDTH-1:0] cur_instr_r;
    logic [DATA_ADDR_WIDTH-1:0]  cur_addr_r;
    logic [LAT_WIDTH-1:0]        lat_r;
    logic                        nxt_valid_r;
    logic [INSTR_DATA_WIDTH-1:0] nxt_instr_r;
    logic                        jump_r;
    logic [DROP_WIDTH-1:0]       drop_r;

    logic                        nxt_occ_s;
    logic                        take_nxt_s;
    logic                        src_valid_s;
    logic [INSTR_DATA_WIDTH-1:0] src_instr_s;
    logic                        src_is_mem_s;
    logic                        latch_cur_s;
    logic                        load_nxt_s;
    logic                        fetch_drop_s;
    logic                        push_s;
    logic                        pop_s;
    logic                        fifo_drop_s;
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic [REC_W-1:0]            rec_s;
    logic [1:0]                  drop_inc_s;
    logic [DROP_WIDTH+1:0]       drop_sum_s;
    logic [DROP_WIDTH-1:0]       drop_nxt_s;

    // Fetch arbitration: a jump invalidates the prefetch before it can be consumed
    always_comb begin
        nxt_occ_s    = nxt_valid_r & ~jump_done;
        take_nxt_s   = (state_r == ST_IDLE) & nxt_occ_s;
        src_valid_s  = take_nxt_s | ((state_r == ST_IDLE) & instr_rvalid);
        if (take_nxt_s) begin
            src_instr_s = nxt_instr_r;
        end else begin
            src_instr_s = instr_rdata;
        end
        src_is_mem_s = is_mem_opcode(src_instr_s[6:0]);
        latch_cur_s  = src_valid_s & src_is_mem_s;
        if (state_r == ST_IDLE) begin
            load_nxt_s   = instr_rvalid & take_nxt_s;
            fetch_drop_s = 1'b0;
        end else begin
            load_nxt_s   = instr_rvalid & ~nxt_occ_s;
            fetch_drop_s = instr_rvalid & nxt_occ_s;
        end
        push_s      = (src_valid_s & ~src_is_mem_s) |
                      ((state_r == ST_WAIT_RVALID) & data_mem_rvalid);
        pop_s       = ~fifo_empty_s & trace_ready_i;
        fifo_drop_s = push_s & fifo_full_s & ~pop_s;
        drop_inc_s  = {1'b0, fetch_drop_s} + {1'b0, fifo_drop_s};
        drop_sum_s  = {2'b00, drop_r} + {{DROP_WIDTH{1'b0}}, drop_inc_s};
        if (drop_sum_s > {2'b00, {DROP_WIDTH{1'b1}}}) begin
            drop_nxt_s = {DROP_WIDTH{1'b1}};
        end else begin
            drop_nxt_s = drop_sum_s[DROP_WIDTH-1:0];
        end
    end

`ifdef GOURAM_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_r;
    logic [TS_WIDTH-1:0] nxt_ts_r;
    logic [TS_WIDTH-1:0] cur_ts_r;
    logic [TS_WIDTH-1:0] src_ts_s;

    assign src_ts_s = take_nxt_s ? nxt_ts_r : ts_r;

    // Free-running stamp and the stamps that travel with the held fetches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_r     <= '0;
            nxt_ts_r <= '0;
            cur_ts_r <= '0;
        end else begin
            ts_r <= ts_r + TS_WIDTH'(1);
            if (load_nxt_s) begin
                nxt_ts_r <= ts_r;
            end
            if (latch_cur_s) begin
                cur_ts_r <= src_ts_s;
            end
        end
    end
`endif

    // Record assembly: completed memory transaction, else the non-memory fetch
    always_comb begin
        rec_s           = '0;
        rec_s[JUMP_BIT] = jump_r | jump_done;
        if (state_r == ST_WAIT_RVALID) begin
            rec_s[MEM_BIT]                         = 1'b1;
            rec_s[INSTR_LSB +: INSTR_DATA_WIDTH]   = cur_instr_r;
            rec_s[ADDR_LSB +: DATA_ADDR_WIDTH]     = cur_addr_r;
            rec_s[LAT_LSB +: LAT_WIDTH]            = lat_r;
`ifdef GOURAM_TIMESTAMP_EN
            rec_s[0 +: TS_WIDTH]                   = cur_ts_r;
`endif
        end else begin
            rec_s[INSTR_LSB +: INSTR_DATA_WIDTH]   = src_instr_s;
`ifdef GOURAM_TIMESTAMP_EN
            rec_s[0 +: TS_WIDTH]                   = src_ts_s;
`endif
        end
    end

    // Transaction FSM, prefetch slot, sticky jump flag and drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cur_instr_r <= '0;
            cur_addr_r  <= '0;
            lat_r       <= '0;
            nxt_valid_r <= 1'b0;
            nxt_instr_r <= '0;
            jump_r      <= 1'b0;
            drop_r      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (latch_cur_s) begin
                        cur_instr_r <= src_instr_s;
                        state_r     <= ST_WAIT_GNT;
                    end
                end
                ST_WAIT_GNT: begin
                    if (data_mem_req && data_mem_grant) begin
                        cur_addr_r <= data_mem_addr;
                        lat_r      <= LAT_WIDTH'(1);
                        state_r    <= ST_WAIT_RVALID;
                    end
                end
                ST_WAIT_RVALID: begin
                    if (data_mem_rvalid) begin
                        state_r <= ST_IDLE;
                    end else if (lat_r != {LAT_WIDTH{1'b1}}) begin
                        lat_r <= lat_r + LAT_WIDTH'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            if (load_nxt_s) begin
                nxt_valid_r <= 1'b1;
                nxt_instr_r <= instr_rdata;
            end else if (take_nxt_s || jump_done) begin
                nxt_valid_r <= 1'b0;
            end
            if (push_s) begin
                jump_r <= 1'b0;
            end else if (jump_done) begin
                jump_r <= 1'b1;
            end
            drop_r <= drop_nxt_s;
        end
    end

    gouram_trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (rec_s),
        .pop       (pop_s),
        .pop_data  (trace_data_o),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign trace_valid_o = ~fifo_empty_s;
    assign drop_count_o  = drop_r;

endmodule

// File: tb/tb_gouram_trace_buffer.sv
// Self-checking bench for gouram_trace_buffer: directed scenarios then random traffic,
// compared every cycle against a transaction-level reference model.
module tb_gouram_trace_buffer;

    localparam int IW    = 32;
    localparam int AW    = 32;
    localparam int LW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
`ifdef GOURAM_TIMESTAMP_EN
    localparam int TSW = 32;
`else
    localparam int TSW = 0;
`endif
    localparam int RW = 2 + IW + AW + LW + TSW;

    localparam logic [31:0] ADD_I  = 32'h00000033;
    localparam logic [31:0] LW_I   = 32'h0000a103;
    localparam logic [31:0] SW_I   = 32'h00112023;
    localparam logic [31:0] ADDI_I = 32'h00100093;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          jump_done = 1'b0;
    logic          instr_rvalid = 1'b0;
    logic [IW-1:0] instr_rdata = '0;
    logic          data_mem_req = 1'b0;
    logic [AW-1:0] data_mem_addr = '0;
    logic          data_mem_grant = 1'b0;
    logic          data_mem_rvalid = 1'b0;
    logic          trace_valid_o;
    logic          trace_ready_i = 1'b0;
    logic [RW-1:0] trace_data_o;
    logic [DW-1:0] drop_count_o;

    always #5 clk = ~clk;

    gouram_trace_buffer #(
        .INSTR_DATA_WIDTH (IW),
        .DATA_ADDR_WIDTH  (AW),
        .LAT_WIDTH        (LW),
        .TS_WIDTH         (32),
        .FIFO_DEPTH       (DEPTH),
        .DROP_WIDTH       (DW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .jump_done       (jump_done),
        .instr_rvalid    (instr_rvalid),
        .instr_rdata     (instr_rdata),
        .data_mem_req    (data_mem_req),
        .data_mem_addr   (data_mem_addr),
        .data_mem_grant  (data_mem_grant),
        .data_mem_rvalid (data_mem_rvalid),
        .trace_valid_o   (trace_valid_o),
        .trace_ready_i   (trace_ready_i),
        .trace_data_o    (trace_data_o),
        .drop_count_o    (drop_count_o)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: queue of records, one prefetch slot, one memory transaction
    logic [RW-1:0]   q[$];
    bit              pf_has;
    logic [31:0]     pf_instr;
    longint unsigned pf_ts;
    int              phase;
    logic [31:0]     m_instr;
    longint unsigned m_ts;
    logic [31:0]     m_addr;
    int              gnt_cyc;
    bit              jpend;
    int              drops;
    longint unsigned tsv;
    int              cyc;

    function automatic bit is_mem(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        return (op == 7'h03) || (op == 7'h23);
    endfunction

    function automatic logic [RW-1:0] mk_rec(input bit j, input bit m, input logic [31:0] ins,
                                             input logic [31:0] ad, input int lat,
                                             input longint unsigned ts);
        logic [RW-1:0] r;
        logic [LW-1:0] l;
        logic [63:0]   tsm;
        l   = LW'((lat > 65535) ? 65535 : lat);
        tsm = (TSW == 0) ? 64'd0 : ((64'd1 << TSW) - 64'd1);
        r   = RW'({j, m, ins, ad, l});
        r   = r << TSW;
        r   = r | RW'(64'(ts) & tsm);
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        pf_has = 1'b0; pf_instr = '0; pf_ts = 0;
        phase = 0; m_instr = '0; m_ts = 0; m_addr = '0; gnt_cyc = 0;
        jpend = 1'b0; drops = 0; tsv = 0; cyc = 0;
    endtask

    task automatic model_step();
        bit pop, full, has_eff, push, src;
        logic [31:0] s_ins;
        longint unsigned s_ts;
        logic [RW-1:0] rec;
        int add;
        add  = 0;
        push = 1'b0;
        rec  = '0;
        pop  = (q.size() > 0) && trace_ready_i;
        full = (q.size() == DEPTH);
        has_eff = pf_has && !jump_done;
        pf_has  = has_eff;
        if (phase == 0) begin
            src   = has_eff || instr_rvalid;
            s_ins = has_eff ? pf_instr : instr_rdata;
            s_ts  = has_eff ? pf_ts : tsv;
            if (has_eff) begin
                pf_has = 1'b0;
                if (instr_rvalid) begin
                    pf_has = 1'b1; pf_instr = instr_rdata; pf_ts = tsv;
                end
            end
            if (src) begin
                if (is_mem(s_ins)) begin
                    phase = 1; m_instr = s_ins; m_ts = s_ts;
                end else begin
                    push = 1'b1;
                    rec  = mk_rec(jpend || jump_done, 1'b0, s_ins, 32'h0, 0, s_ts);
                end
            end
        end else begin
            if (instr_rvalid) begin
                if (pf_has) add++;
                else begin
                    pf_has = 1'b1; pf_instr = instr_rdata; pf_ts = tsv;
                end
            end
            if (phase == 1) begin
                if (data_mem_req && data_mem_grant) begin
                    m_addr = data_mem_addr; gnt_cyc = cyc; phase = 2;
                end
            end else if (data_mem_rvalid) begin
                push  = 1'b1;
                rec   = mk_rec(jpend || jump_done, 1'b1, m_instr, m_addr, cyc - gnt_cyc, m_ts);
                phase = 0;
            end
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            jpend = 1'b0;
            if (full && !pop) add++;
            else q.push_back(rec);
        end else if (jump_done) begin
            jpend = 1'b1;
        end
        drops = (drops + add > 65535) ? 65535 : drops + add;
        tsv++;
        cyc++;
    endtask

    task automatic check_outputs(input string tag);
        logic exp_v;
        exp_v = (q.size() > 0);
        checks++;
        assert (trace_valid_o === exp_v) else begin
            failures++;
            $error("FAIL %s valid obs=%0b exp=%0b", tag, trace_valid_o, exp_v);
        end
        if (exp_v) begin
            checks++;
            assert (trace_data_o === q[0]) else begin
                failures++;
                $error("FAIL %s data obs=%h exp=%h", tag, trace_data_o, q[0]);
            end
        end
        checks++;
        assert (drop_count_o === DW'(drops)) else begin
            failures++;
            $error("FAIL %s drop obs=%0d exp=%0d", tag, drop_count_o, drops);
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_outputs(tag);
    endtask

    task automatic fetch(input logic [31:0] ins);
        instr_rvalid = 1'b1;
        instr_rdata  = ins;
    endtask

    initial begin
        model_reset();
        repeat (2) step("reset");
        chk("reset_valid", 128'(trace_valid_o), 128'(1'b0));
        chk("reset_data",  128'(trace_data_o),  128'(1'b0));
        chk("reset_drop",  128'(drop_count_o),  128'(1'b0));
        rst_n = 1'b1;

        // Non-memory fetch at timestamp 5
        repeat (5) step("idle");
        fetch(ADD_I); step("add_fetch");
        instr_rvalid = 1'b0;
        chk("add_valid", 128'(trace_valid_o), 128'(1'b1));
        chk("add_rec", 128'(trace_data_o), 128'(mk_rec(1'b0, 1'b0, ADD_I, 32'h0, 0, 5)));
        trace_ready_i = 1'b1;
        step("add_pop");

        // Load, grant at 0x1000, rvalid three cycles after grant
        fetch(LW_I); step("lw_fetch");
        instr_rvalid = 1'b0;
        data_mem_req = 1'b1; data_mem_grant = 1'b1; data_mem_addr = 32'h1000;
        step("lw_gnt");
        data_mem_req = 1'b0; data_mem_grant = 1'b0;
        repeat (2) step("lw_wait");
        data_mem_rvalid = 1'b1; step("lw_rvalid");
        data_mem_rvalid = 1'b0;
        chk("lw_mem",  128'(trace_data_o[TSW+LW+AW+IW]), 128'(1'b1));
        chk("lw_addr", 128'(trace_data_o[TSW+LW +: AW]), 128'(32'h1000));
        chk("lw_lat",  128'(trace_data_o[TSW +: LW]),    128'(16'd3));

        // Two fetches while waiting for rvalid: second dropped
        fetch(LW_I); step("lw2_fetch");
        instr_rvalid = 1'b0;
        data_mem_req = 1'b1; data_mem_grant = 1'b1; step("lw2_gnt");
        data_mem_req = 1'b0; data_mem_grant = 1'b0;
        fetch(ADD_I); step("pf1");
        fetch(ADDI_I); step("pf2_drop");
        instr_rvalid = 1'b0;
        data_mem_rvalid = 1'b1; step("lw2_rvalid");
        data_mem_rvalid = 1'b0;
        chk("pf_drop", 128'(drop_count_o), 128'(16'd1));
        step("pf1_emit");
        chk("pf1_instr", 128'(trace_data_o[TSW+LW+AW +: IW]), 128'(ADD_I));

        // jump_done discards the prefetch and tags the next record
        fetch(LW_I); step("lw3_fetch");
        fetch(ADDI_I); step("lw3_pf");
        instr_rvalid = 1'b0;
        jump_done = 1'b1; step("jump");
        jump_done = 1'b0;
        data_mem_req = 1'b1; data_mem_grant = 1'b1; step("lw3_gnt");
        data_mem_req = 1'b0; data_mem_grant = 1'b0;
        data_mem_rvalid = 1'b1; step("lw3_rvalid");
        data_mem_rvalid = 1'b0;
        chk("jump_bit",   128'(trace_data_o[TSW+LW+AW+IW+1]), 128'(1'b1));
        chk("jump_instr", 128'(trace_data_o[TSW+LW+AW +: IW]), 128'(LW_I));
        chk("jump_drop",  128'(drop_count_o), 128'(16'd1));
        step("jump_after");
        chk("jump_pf_gone", 128'(trace_valid_o), 128'(1'b0));

        // Back-pressure: ten fetches into an eight-deep FIFO
        trace_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            fetch(ADD_I | (32'(i) << 7));
            step("full_fill");
        end
        instr_rvalid = 1'b0;
        chk("full_drop",  128'(drop_count_o), 128'(16'd3));
        repeat (3) step("full_hold");
        chk("full_head", 128'(trace_data_o[TSW+LW+AW +: IW]), 128'(ADD_I));
        trace_ready_i = 1'b1;
        repeat (9) step("drain");
        chk("drained", 128'(trace_valid_o), 128'(1'b0));

        // Reset while waiting for grant
        fetch(LW_I); step("rst_lw");
        instr_rvalid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 128'(trace_valid_o), 128'(1'b0));
        chk("rst_data",  128'(trace_data_o),  128'(1'b0));
        chk("rst_drop",  128'(drop_count_o),  128'(1'b0));
        step("rst_hold");
        rst_n = 1'b1;
        fetch(ADD_I); step("rst_add");
        instr_rvalid = 1'b0;
        chk("rst_add_valid", 128'(trace_valid_o), 128'(1'b1));
        chk("rst_add_instr", 128'(trace_data_o[TSW+LW+AW +: IW]), 128'(ADD_I));

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            instr_rvalid = ($urandom_range(0, 99) < 40);
            case ($urandom_range(0, 3))
                0:       instr_rdata = ADD_I;
                1:       instr_rdata = LW_I;
                2:       instr_rdata = SW_I;
                default: instr_rdata = $urandom;
            endcase
            data_mem_req    = ($urandom_range(0, 99) < 50);
            data_mem_grant  = ($urandom_range(0, 99) < 50);
            data_mem_addr   = $urandom;
            data_mem_rvalid = ($urandom_range(0, 99) < 30);
            jump_done       = ($urandom_range(0, 99) < 5);
            trace_ready_i   = ($urandom_range(0, 99) < ((i < 500) ? 20 : 70));
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gouram_trace_buffer.md
# gouram_trace_buffer

Parametrised successor to the single-record Gouram trace front end. Pairs each fetched instruction with its data-memory transaction (address, grant-to-rvalid latency), stamps it, and queues complete trace records in an internal FIFO drained through a valid/ready port. Sits beside the core, on the instruction-memory and data-memory ports, and feeds the trace sink or debug transport.

## Interface
- INSTR_DATA_WIDTH, 32, fetched instruction width
- DATA_ADDR_WIDTH, 32, data-memory address width
- LAT_WIDTH, 16, memory latency field width
- TS_WIDTH, 32, timestamp field width
- FIFO_DEPTH, 8, record FIFO depth (power of two, ≥2)
- DROP_WIDTH, 16, dropped-record counter width
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- jump_done  in  1  core has redirected the PC
- instr_rvalid  in  1  instruction fetch data valid
- instr_rdata  in  INSTR_DATA_WIDTH  fetched instruction
- data_mem_req  in  1  data request
- data_mem_addr  in  DATA_ADDR_WIDTH  data address
- data_mem_grant  in  1  data request granted
- data_mem_rvalid  in  1  data response valid
- trace_valid_o  out  1  record available
- trace_ready_i  in  1  sink accepts record
- trace_data_o  out  REC_W  record {jump, mem, instr, addr, latency[, timestamp]}
- drop_count_o  out  DROP_WIDTH  saturating count of lost records

## Operation
- Memory instruction: opcode bits [6:0] = 7'b0000011 (load) or 7'b0100011 (store); all others non-memory.
- Free-running timestamp counter, wraps modulo 2^TS_WIDTH; sampled in the fetch cycle.
- FSM IDLE / WAIT_GNT / WAIT_RVALID, with current and next record registers.
- IDLE with fetch source (next register if occupied, else instr_rvalid): non-memory → push record (mem=0, addr=0, latency=0); memory → latch into current, go WAIT_GNT.
- WAIT_GNT: data_mem_req & data_mem_grant → latch addr, latency=1, go WAIT_RVALID.
- WAIT_RVALID: latency increments each cycle, saturating at all-ones; data_mem_rvalid → push record, go IDLE.
- instr_rvalid outside IDLE (or in IDLE while next is being consumed) → loaded into next; if next already occupied → fetch dropped, drop_count_o increments.
- jump_done: sets sticky jump flag carried by the next pushed record, then cleared; in the same cycle clears next register (wrong-path fetch), no drop counted.
- Grant/rvalid in IDLE: ignored.
- Push when FIFO full (and no pop that cycle) → record discarded, drop_count_o increments; saturates at all-ones.
- Simultaneous push and pop on full FIFO: both succeed.

## Timing
- Reset: trace_valid_o=0, trace_data_o=0, drop_count_o=0, FSM=IDLE, next empty, jump flag 0, timestamp 0, FIFO empty.
- Non-memory fetch in cycle N → trace_valid_o=1 in N+1 (empty FIFO).
- Memory record: data_mem_rvalid in cycle M → trace_valid_o=1 in M+1.
- Latency = cycles from grant cycle to rvalid cycle; rvalid one cycle after grant reports 1.
- Pop on trace_valid_o & trace_ready_i; trace_data_o stable while valid and not ready.
- rst_n low mid-transaction: all state cleared immediately, pending record lost, not counted.

## Configuration
- GOURAM_TIMESTAMP_EN defined: timestamp counter present, timestamp field in LSBs, REC_W = 2+INSTR_DATA_WIDTH+DATA_ADDR_WIDTH+LAT_WIDTH+TS_WIDTH.
- Undefined: no counter, field omitted, REC_W = 2+INSTR_DATA_WIDTH+DATA_ADDR_WIDTH+LAT_WIDTH; all else identical.

## Structure
- gouram_trace_pkg: load/store opcode constants, FSM state enum, record field offset functions.
- Sub-module gouram_trace_fifo: synchronous FIFO, parameters WIDTH and DEPTH, push/pop/full/empty, registered output.

## Test plan
- ADD (0x00000033) fetched at timestamp 5 → record mem=0, instr=0x00000033, timestamp=5, valid next cycle.
- LW (0x0000a103), grant with addr 0x1000, rvalid 3 cycles after grant → mem=1, addr=0x1000, latency=3.
- Two fetches during WAIT_RVALID → second dropped, drop_count_o=1; first emitted after LW record.
- jump_done while next holds prefetch → prefetch discarded, following record has jump=1, drop_count_o unchanged.
- trace_ready_i=0, 10 non-memory fetches, FIFO_DEPTH=8 → 8 records held, drop_count_o=2, data stable.
- rst_n low in WAIT_GNT → all outputs zero, next fetch traced normally.
